// File: rtl/mul3_stream_ctrl.sv
// mul3_stream_ctrl: valid/ready front end and FIFO back end for the masked
// mod-3 multiply-add gadget, with credit-based backpressure.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for a masked triple
//   in_e, in_v, in_a     masked trits {bit1 shares, bit0 shares}, 2*d bits
//   in_last              final coefficient of a polynomial
//   rnd_in               fresh randomness, forwarded to the gadget
//   g_e, g_v, g_a        registered operands to the gadget
//   g_rnd                randomness to the gadget (wired through)
//   g_out                gadget result, valid LAT+1 cycles after g_* issue
//   out_valid/out_ready  output handshake
//   out_data, out_last   FIFO head
//   done                 pulse when a last-tagged result is consumed
//   busy                 results in flight or buffered
module mul3_stream_ctrl #(
    parameter  int d          = 2,
    parameter  int LAT        = 5,
    parameter  int FIFO_DEPTH = 8,
    localparam int NRND       = 6 * d * (d - 1) / 2,
    localparam int W          = 2 * d
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    in_e,
    input  logic [W-1:0]    in_v,
    input  logic [W-1:0]    in_a,
    input  logic            in_last,
    input  logic [NRND-1:0] rnd_in,
    output logic [W-1:0]    g_e,
    output logic [W-1:0]    g_v,
    output logic [W-1:0]    g_a,
    output logic [NRND-1:0] g_rnd,
    input  logic [W-1:0]    g_out,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_data,
    output logic            out_last,
    output logic            done,
    output logic            busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int TS = LAT + 2;

    logic           accept;
    logic           pop;
    logic           wr;
    logic [TS-1:0]  tag_v;
    logic [TS-1:0]  tag_l;
    logic [CW-1:0]  credits;
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    count;
    logic [W:0]     mem [FIFO_DEPTH];
    logic [W:0]     head;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Tag at the top stage lines up with the gadget result on g_out.
    assign wr     = tag_v[TS-1];

    assign g_rnd  = rnd_in;

    // Operand registers hold masked shares untouched; no reset so that
    // share values are never forced to a common constant.
    always_ff @(posedge clk) begin
        if (accept) begin
            g_e <= in_e;
            g_v <= in_v;
            g_a <= in_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_l <= '0;
        end else begin
            tag_v <= {tag_v[TS-2:0], accept};
            tag_l <= {tag_l[TS-2:0], accept & in_last};
        end
    end

    // Credits cover in-flight tags plus buffered entries, so every
    // accepted triple already owns a FIFO slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= '0;
        end else begin
            unique case (1'b1)
                accept & ~pop: credits <= credits + 1'b1;
                pop & ~accept: credits <= credits - 1'b1;
                default:       credits <= credits;
            endcase
        end
    end

    assign in_ready = (credits < CW'(FIFO_DEPTH));
    assign busy     = (credits != '0);

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= {tag_l[TS-1], g_out};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case (1'b1)
                wr & ~pop: count <= count + 1'b1;
                pop & ~wr: count <= count - 1'b1;
                default:   count <= count;
            endcase
        end
    end

    assign head      = mem[rptr];
    assign out_valid = (count != '0);
    assign out_data  = head[W-1:0];
    assign out_last  = out_valid & head[W];
    assign done      = pop & head[W];

endmodule

// File: tb/tb_mul3_stream_ctrl.sv
// tb_mul3_stream_ctrl: scoreboard bench for mul3_stream_ctrl with a
// behavioural masked mod-3 gadget model on the g_* ports.
module tb_mul3_stream_ctrl;

    localparam int D    = 2;
    localparam int LAT  = 5;
    localparam int DEP  = 8;
    localparam int NRND = 6;

    logic            clk = 0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_e, in_v, in_a;
    logic            in_last;
    logic [NRND-1:0] rnd_in;
    logic [3:0]      g_e, g_v, g_a;
    logic [NRND-1:0] g_rnd;
    logic [3:0]      g_out;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_data;
    logic            out_last;
    logic            done;
    logic            busy;

    mul3_stream_ctrl #(.d(D), .LAT(LAT), .FIFO_DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_e(in_e), .in_v(in_v), .in_a(in_a), .in_last(in_last),
        .rnd_in(rnd_in),
        .g_e(g_e), .g_v(g_v), .g_a(g_a), .g_rnd(g_rnd), .g_out(g_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    bit rr_mode = 0;
    logic [1:0] cur_exp;
    logic [2:0] q[$];

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic fail(input string n);
        checks++;
        errors++;
        $display("FAIL %s (cyc %0d)", n, cyc);
    endtask

    function automatic logic [1:0] recomb(input logic [3:0] x);
        return {x[3] ^ x[2], x[1] ^ x[0]};
    endfunction

    function automatic logic [3:0] maskit(input logic [1:0] v);
        logic m1, m0;
        m1 = 1'($urandom);
        m0 = 1'($urandom);
        return {v[1] ^ m1, m1, v[0] ^ m0, m0};
    endfunction

    function automatic logic [1:0] golden(input logic [1:0] e, v, a);
        int r;
        r = (int'(e) * int'(v) + int'(a)) % 3;
        return 2'(r);
    endfunction

    // Gadget model: input register plus LAT stages, re-masked output.
    logic [3:0] gp [LAT+1];
    always @(posedge clk) begin
        gp[0] <= maskit(golden(recomb(g_e), recomb(g_v), recomb(g_a)));
        for (int k = 1; k <= LAT; k++) gp[k] <= gp[k-1];
    end
    assign g_out = gp[LAT];

    always @(posedge clk) begin
        cyc++;
        #1;
        rnd_in = NRND'($urandom);
        if (rr_mode) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor: pushes on accept, pops and compares on consume.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("g_rnd", int'(g_rnd), int'(rnd_in));
            if (in_valid && in_ready) q.push_back({in_last, cur_exp});
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail("unexpected_output");
                end else begin
                    logic [2:0] x;
                    x = q.pop_front();
                    chk("out_data", int'(recomb(out_data)), int'(x[1:0]));
                    chk("out_last", int'(out_last), int'(x[2]));
                    chk("done", int'(done), int'(x[2]));
                end
            end else if (done) begin
                fail("done_without_pop");
            end
            if (done) done_cnt++;
        end
    end

    task automatic set_in(input logic [1:0] e, v, a, x, input bit last);
        in_e    = maskit(e);
        in_v    = maskit(v);
        in_a    = maskit(a);
        cur_exp = x;
        in_last = last;
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [1:0] e, v, a, x,
                        input bit last, input bit rv);
        bit acc;
        int guard;
        acc = 0;
        guard = 0;
        set_in(e, v, a, x, last);
        in_valid = rv ? 1'($urandom_range(0, 1)) : 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                guard++;
                if (guard > 3000) begin
                    fail("send_timeout");
                    break;
                end
                if (rv) in_valid = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 0;
        if (acc) chk("g_e_raw", int'(g_e), int'(in_e));
    endtask

    task automatic wait_lat(input string n);
        int t0;
        int g;
        t0 = cyc;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!out_valid && g < 30);
        if (!out_valid) fail({n, "_timeout"});
        else chk(n, cyc - t0, LAT + 2);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((q.size() != 0 || out_valid) && g < 5000) begin
            @(posedge clk);
            g++;
        end
        #1;
        if (g >= 5000) fail("drain_timeout");
    endtask

    typedef struct packed {
        logic [1:0] e, v, a, x;
    } vec_t;

    vec_t tab [12] = '{
        '{2'd0, 2'd0, 2'd0, 2'd0}, '{2'd1, 2'd1, 2'd0, 2'd1},
        '{2'd1, 2'd1, 2'd1, 2'd2}, '{2'd2, 2'd2, 2'd0, 2'd1},
        '{2'd2, 2'd2, 2'd2, 2'd0}, '{2'd2, 2'd1, 2'd0, 2'd2},
        '{2'd2, 2'd1, 2'd2, 2'd1}, '{2'd1, 2'd2, 2'd2, 2'd1},
        '{2'd0, 2'd2, 2'd1, 2'd1}, '{2'd2, 2'd0, 2'd2, 2'd2},
        '{2'd1, 2'd0, 2'd0, 2'd0}, '{2'd2, 2'd2, 2'd1, 2'd2}
    };

    initial begin
        rst_n = 0;
        in_valid = 0;
        out_ready = 0;
        in_last = 0;
        in_e = 0; in_v = 0; in_a = 0;
        cur_exp = 0;
        rnd_in = 0;
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        #10 rst_n = 1;

        // 1: single triple, latency and value 1*2+1 = 0
        while (cyc < 9) @(posedge clk);
        #1;
        out_ready = 1;
        send(2'd1, 2'd2, 2'd1, 2'd0, 0, 0);
        wait_lat("t1_latency");
        drain();
        chk("t1_done_cnt", done_cnt, 0);

        // 2: burst of 12 against a stalled consumer
        out_ready = 0;
        for (int i = 0; i < 8; i++)
            send(tab[i].e, tab[i].v, tab[i].a, tab[i].x, 0, 0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("t2_in_ready_full", int'(in_ready), 0);
        chk("t2_out_valid", int'(out_valid), 1);
        chk("t2_q_size", q.size(), 8);
        @(posedge clk);
        #1;
        out_ready = 1;
        for (int i = 8; i < 12; i++)
            send(tab[i].e, tab[i].v, tab[i].a, tab[i].x, 0, 0);
        drain();
        chk("t2_busy_idle", int'(busy), 0);

        // 4: pop and offer in the same cycle at full credits
        out_ready = 0;
        for (int i = 0; i < 8; i++)
            send(tab[i].e, tab[i].v, tab[i].a, tab[i].x, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1;
        set_in(2'd2, 2'd2, 2'd1, 2'd2, 0);
        in_valid = 1;
        @(negedge clk);
        chk("t4_same_cycle_ready", int'(in_ready), 0);
        @(posedge clk);
        #1;
        out_ready = 0;
        @(negedge clk);
        chk("t4_next_cycle_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 0;
        chk("t4_q_size", q.size(), 8);
        out_ready = 1;
        drain();

        // 5: reset with 4 buffered and 3 in flight
        out_ready = 0;
        for (int i = 0; i < 4; i++)
            send(tab[i].e, tab[i].v, tab[i].a, tab[i].x, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        for (int i = 4; i < 7; i++)
            send(tab[i].e, tab[i].v, tab[i].a, tab[i].x, 0, 0);
        #2;
        rst_n = 0;
        #1;
        chk("t5_rst_out_valid", int'(out_valid), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_in_ready", int'(in_ready), 1);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1;
        @(posedge clk);
        #1;
        out_ready = 1;
        send(2'd2, 2'd1, 2'd2, 2'd1, 0, 0);
        wait_lat("t5_latency");
        repeat (15) @(posedge clk);
        #1;
        drain();

        // 6: same values, fresh masking each time
        for (int r = 0; r < 3; r++)
            send(2'd2, 2'd2, 2'd1, 2'd2, 0, 0);
        drain();

        // 3: 761 coefficients, random handshakes on both sides
        done_cnt = 0;
        rr_mode = 1;
        for (int i = 0; i < 761; i++) begin
            logic [1:0] e, v, a;
            e = 2'(i % 3);
            v = 2'((i / 3) % 3);
            a = 2'((i / 9) % 3);
            send(e, v, a, golden(e, v, a), i == 760, 1);
        end
        rr_mode = 0;
        @(posedge clk);
        #1;
        out_ready = 1;
        drain();
        @(negedge clk);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_busy_idle", int'(busy), 0);
        chk("t3_q_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
